// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and decode helpers.
// Segment order is abcdefg, bit6 = a.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // Returns {valid, bcd}.
  function automatic logic [4:0] seg_to_bcd(
    input logic [6:0] seg
  );
    logic [4:0] r;
    r = '0;
    unique case (seg)
      SEG_0:   r = {1'b1, 4'd0};
      SEG_1:   r = {1'b1, 4'd1};
      SEG_2:   r = {1'b1, 4'd2};
      SEG_3:   r = {1'b1, 4'd3};
      SEG_4:   r = {1'b1, 4'd4};
      SEG_5:   r = {1'b1, 4'd5};
      SEG_6:   r = {1'b1, 4'd6};
      SEG_7:   r = {1'b1, 4'd7};
      SEG_8:   r = {1'b1, 4'd8};
      SEG_9:   r = {1'b1, 4'd9};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Returns {ok, idx}.
  function automatic logic [3:0] onehot_index(
    input logic [7:0] sel
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) r[2:0] = 3'(i);
    end
    r[3] = $onehot(sel);
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational abcdefg -> BCD decode.
// valid is low for any pattern that is not 0-9.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] bcd
);

  assign {valid, bcd} = seg_to_bcd(seg);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Rebuilds per-digit BCD values from a multiplexed
// 7-segment display bus.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 3,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   iSel,
  input  logic [6:0]            abcdefg,
  output logic [4*N_DIGITS-1:0] oBCD,
  output logic [N_DIGITS-1:0]   oValid,
  output logic                  oNew,
  output logic [2:0]            oDigit,
  output logic                  oErr,
  output logic [7:0]            oErrCount,
  output logic                  oFrame,
  output logic                  oFrameOk
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  logic [6:0]          seg_in;
  logic [N_DIGITS-1:0] sel_q;
  logic [6:0]          seg_q;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;
  logic [N_DIGITS-1:0] seen;
  logic [N_DIGITS-1:0] seen_next;
  logic [N_DIGITS-1:0] hit;
  logic [N_DIGITS-1:0] valid_next;
  logic [4*N_DIGITS-1:0] bcd_next;
  logic [3:0]          oh_q;
  logic                stable;
  logic                capture;
  logic                frame;
  logic                dec_valid;
  logic [3:0]          dec_bcd;

  assign seg_in = (SEG_ACTIVE_LOW != 0) ? ~abcdefg : abcdefg;
  assign oh_q   = onehot_index(8'(sel_q));

  assign stable = (iSel == sel_q) && (seg_in == seg_q)
                  && $onehot(iSel);

  // Capture exactly once, on the step into saturation.
  assign capture = stable && oh_q[3] && (cnt == CNT_CAP);

  seg7_pattern_decode u_dec (
    .seg   (seg_q),
    .valid (dec_valid),
    .bcd   (dec_bcd)
  );

  always_comb begin
    cnt_next   = '0;
    hit        = '0;
    valid_next = oValid;
    bcd_next   = oBCD;
    if (stable) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      hit[i] = capture && (oh_q[2:0] == 3'(i));
      if (hit[i]) begin
        valid_next[i] = dec_valid;
        if (dec_valid) bcd_next[4*i +: 4] = dec_bcd;
      end
    end
    seen_next = seen | hit;
    frame     = capture && (&seen_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      seg_q     <= '0;
      cnt       <= '0;
      seen      <= '0;
      oBCD      <= '0;
      oValid    <= '0;
      oNew      <= 1'b0;
      oDigit    <= '0;
      oErr      <= 1'b0;
      oErrCount <= '0;
      oFrame    <= 1'b0;
      oFrameOk  <= 1'b0;
    end else begin
      sel_q    <= iSel;
      seg_q    <= seg_in;
      cnt      <= cnt_next;
      oBCD     <= bcd_next;
      oValid   <= valid_next;
      oNew     <= capture;
      oErr     <= capture && !dec_valid;
      oFrame   <= frame;
      oFrameOk <= frame && (&valid_next);
      seen     <= frame ? '0 : seen_next;
      if (capture) oDigit <= oh_q[2:0];
      if (capture && !dec_valid && oErrCount != 8'hFF) begin
        oErrCount <= oErrCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised bench for seg7_scan_decoder against a run-length
// reference model; drives active-high and active-low instances.
module tb_seg7_scan_decoder;

  localparam int S = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] sel;
  logic [6:0] seg;
  logic [6:0] seg_n;
  assign seg_n = ~seg;

  logic [15:0] a_bcd, n_bcd;
  logic [3:0]  a_valid, n_valid;
  logic        a_new, n_new, a_err, n_err;
  logic [2:0]  a_digit, n_digit;
  logic [7:0]  a_cnt, n_cnt;
  logic        a_frame, n_frame, a_ok, n_ok;

  seg7_scan_decoder #(
    .N_DIGITS(4), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .iSel(sel), .abcdefg(seg),
    .oBCD(a_bcd), .oValid(a_valid), .oNew(a_new),
    .oDigit(a_digit), .oErr(a_err), .oErrCount(a_cnt),
    .oFrame(a_frame), .oFrameOk(a_ok)
  );

  seg7_scan_decoder #(
    .N_DIGITS(4), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1)
  ) dut_n (
    .clk(clk), .rst(rst), .iSel(sel), .abcdefg(seg_n),
    .oBCD(n_bcd), .oValid(n_valid), .oNew(n_new),
    .oDigit(n_digit), .oErr(n_err), .oErrCount(n_cnt),
    .oFrame(n_frame), .oFrameOk(n_ok)
  );

  logic [6:0] codes [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011
  };

  int total = 0;
  int bad   = 0;
  int new_count;
  int err_count;

  logic [10:0] prev;
  int          run;
  logic [3:0]  m_bcd [4];
  logic [3:0]  m_valid, m_seen;
  logic        m_new, m_err, m_frame, m_ok;
  logic [2:0]  m_digit;
  int          m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] g);
    for (int i = 0; i < 10; i++) begin
      if (codes[i] == g) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int idx;
    int v;
    m_new = 0; m_err = 0; m_frame = 0; m_ok = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_bcd[i] = '0;
      m_valid = '0; m_seen = '0; m_digit = '0;
      m_cnt = 0; prev = '0; run = 0;
      return;
    end
    if ({sel, seg} == prev) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    prev = {sel, seg};
    if ($countones(sel) == 1 && run == S + 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
      v = lookup(seg);
      m_new = 1;
      m_digit = 3'(idx);
      if (v >= 0) begin
        m_bcd[idx] = 4'(v);
        m_valid[idx] = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        m_frame = 1;
        m_ok = (m_valid == 4'hF);
        m_seen = '0;
      end
    end
  endtask

  task automatic check_outs();
    logic [15:0] eb;
    eb = {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]};
    chk("bcd",   a_bcd,   eb);
    chk("valid", a_valid, m_valid);
    chk("new",   a_new,   m_new);
    chk("digit", a_digit, m_digit);
    chk("err",   a_err,   m_err);
    chk("ecnt",  a_cnt,   m_cnt);
    chk("frame", a_frame, m_frame);
    chk("ok",    a_ok,    m_ok);
    chk("n_bcd",   n_bcd,   eb);
    chk("n_valid", n_valid, m_valid);
    chk("n_new",   n_new,   m_new);
    chk("n_digit", n_digit, m_digit);
    chk("n_err",   n_err,   m_err);
    chk("n_ecnt",  n_cnt,   m_cnt);
    chk("n_frame", n_frame, m_frame);
    chk("n_ok",    n_ok,    m_ok);
  endtask

  task automatic step(input logic [3:0] s,
                      input logic [6:0] g,
                      input logic r);
    @(negedge clk);
    sel = s; seg = g; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    if (a_new) new_count++;
    if (a_err) err_count++;
  endtask

  task automatic hold(input logic [3:0] s,
                      input logic [6:0] g,
                      input int n);
    repeat (n) step(s, g, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] rs;
    logic [6:0] rg;
    sel = '0; seg = '0; rst = 1'b1;
    new_count = 0; err_count = 0;
    step(4'b0000, 7'b0, 1'b1);
    step(4'b0000, 7'b0, 1'b1);
    chk("rst_bcd", a_bcd, 0);
    chk("rst_valid", a_valid, 0);

    hold(4'b0001, 7'b1111110, 4);
    chk("t1_new", a_new, 1);
    chk("t1_digit", a_digit, 0);
    chk("t1_bcd0", a_bcd[3:0], 0);
    chk("t1_valid", a_valid, 4'b0001);
    new_count = 0;
    hold(4'b0001, 7'b1111110, 3);
    chk("t1_norep", new_count, 0);

    hold(4'b0001, 7'b1101101, 5);
    hold(4'b0010, 7'b1011011, 5);
    hold(4'b0100, 7'b1110000, 5);
    hold(4'b1000, 7'b1111011, 4);
    chk("t2_frame", a_frame, 1);
    chk("t2_ok", a_ok, 1);
    hold(4'b1000, 7'b1111011, 1);
    chk("t2_bcd", a_bcd, 16'h9752);

    hold(4'b0010, 7'b1001011, 4);
    chk("t3_err", a_err, 1);
    chk("t3_ecnt", a_cnt, 1);
    chk("t3_valid1", a_valid[1], 0);
    chk("t3_bcd1", a_bcd[7:4], 5);
    hold(4'b0010, 7'b1001011, 1);
    hold(4'b0001, 7'b1111001, 5);
    hold(4'b0100, 7'b0110011, 5);
    hold(4'b1000, 7'b1011111, 4);
    chk("t3_frame", a_frame, 1);
    chk("t3_ok", a_ok, 0);
    hold(4'b1000, 7'b1011111, 1);

    new_count = 0; err_count = 0;
    hold(4'b0011, 7'b1111111, 10);
    hold(4'b0100, 7'b1111111, 2);
    chk("t4_new", new_count, 0);
    chk("t4_err", err_count, 0);

    hold(4'b0100, 7'b0110000, 4);
    chk("t5_bcd2", n_bcd[11:8], 1);
    chk("t5_valid2", n_valid[2], 1);

    step(4'b0000, 7'b0, 1'b1);
    hold(4'b0001, 7'b1111110, 3);
    step(4'b0001, 7'b1111110, 1'b1);
    chk("t6_new", a_new, 0);
    chk("t6_bcd", a_bcd, 0);
    new_count = 0;
    hold(4'b0001, 7'b1111110, 3);
    chk("t6_early", new_count, 0);
    hold(4'b0001, 7'b1111110, 1);
    chk("t6_cap", a_new, 1);

    for (int d = 0; d < 10; d++) begin
      rs = 4'b0001 << (d % 4);
      hold(rs, codes[d], 5);
    end

    repeat (140) begin
      hold(4'b0001, 7'b0000001, 4);
      hold(4'b0010, 7'b0000010, 4);
    end
    chk("sat_ecnt", a_cnt, 255);
    chk("sat_necnt", n_cnt, 255);

    repeat (600) begin
      r = $urandom_range(0, 9);
      if (r < 8) rs = 4'b0001 << (r % 4);
      else if (r == 8) rs = 4'b0000;
      else rs = 4'b0110;
      if ($urandom_range(0, 1) == 1) rg = codes[$urandom_range(0, 9)];
      else rg = 7'($urandom);
      if ($urandom_range(0, 99) == 0) step(rs, rg, 1'b1);
      hold(rs, rg, $urandom_range(1, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
